// File: rtl/down_sampler_pkg.sv
// Shared constants and FSM encoding for the 2:1 down-sampler (full-size raster geometry, pixel width).
// Latency: n/a (definitions only).
// Backpressure: n/a (definitions only).
package down_sampler_pkg;
    localparam int PIX_W      = 8;
    localparam int IMG_W_FULL = 1600;
    localparam int IMG_H_FULL = 1200;
    localparam int IMG_W_HALF = IMG_W_FULL / 2;
    localparam int IMG_H_HALF = IMG_H_FULL / 2;
    localparam int CNT_W      = 11;

    typedef enum logic {
        S_KEEP = 1'b0,
        S_DROP = 1'b1
    } ds_state_e;
endpackage

// File: rtl/down_sampler_line_buffer.sv
// Simple dual-port line buffer holding horizontal pixel-pair sums of the previous kept row.
// Latency: 1 cycle read (registered), synchronous write.
// Backpressure: none; read data holds while rd_en is low.
module ds_line_buffer #(
    parameter int DEPTH = 800,
    parameter int AW    = 10,
    parameter int DW    = 9
) (
    input  logic          clk,
    input  logic          wr_en,
    input  logic [AW-1:0] wr_addr,
    input  logic [DW-1:0] wr_dat,
    input  logic          rd_en,
    input  logic [AW-1:0] rd_addr,
    output logic [DW-1:0] rd_dat
);
    logic [DW-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_addr] <= wr_dat;
    end

    always_ff @(posedge clk) begin
        if (rd_en) rd_dat <= mem[rd_addr];
    end
endmodule

// File: rtl/down_sampler.sv
// 2:1 raster decimator: even pixel of every even row; 2x2 rounded box average when DOWN_SAMPLER_AVG_EN is defined.
// Latency: 1 cycle from the accepted input pixel to valid_out.
// Backpressure: rd_en drops combinationally on empty or prog_full; the prog_full margin absorbs in-flight writes.
module down_sampler #(
    parameter int IMG_W = down_sampler_pkg::IMG_W_FULL,
    parameter int IMG_H = down_sampler_pkg::IMG_H_FULL,
    parameter int PIX_W = down_sampler_pkg::PIX_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [PIX_W-1:0] din,
    input  logic             valid,
    input  logic             empty,
    output logic             rd_en,
    input  logic             prog_full,
    output logic [PIX_W-1:0] dout,
    output logic             valid_out,
    output logic             frame_done
);
    import down_sampler_pkg::*;

    logic [CNT_W-1:0] col;
    logic [CNT_W-1:0] row;
    ds_state_e        state;
    ds_state_e        state_nxt;
    logic             col_last;
    logic             row_last;
    logic             emit;
    logic [PIX_W-1:0] pix_nxt;

    assign rd_en    = !empty && !prog_full;
    assign col_last = (col == CNT_W'(IMG_W - 1));
    assign row_last = (row == CNT_W'(IMG_H - 1));

    always_comb begin
        state_nxt = state;
        emit      = 1'b0;
        case (state)
            S_KEEP: if (valid && col_last) state_nxt = S_DROP;
            S_DROP: if (valid && col_last) state_nxt = S_KEEP;
        endcase
`ifdef DOWN_SAMPLER_AVG_EN
        emit = valid && (state == S_DROP) && col[0];
`else
        emit = valid && (state == S_KEEP) && !col[0];
`endif
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= S_KEEP;
        else      state <= state_nxt;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            col <= '0;
            row <= '0;
        end else if (valid) begin
            if (col_last) begin
                col <= '0;
                row <= row_last ? '0 : row + 1'b1;
            end else begin
                col <= col + 1'b1;
            end
        end
    end

`ifdef DOWN_SAMPLER_AVG_EN
    localparam int LB_DEPTH = IMG_W / 2;
    localparam int LB_AW    = $clog2(LB_DEPTH);

    logic [PIX_W-1:0] prev;
    logic [PIX_W:0]   pair;
    logic [PIX_W:0]   lb_rd_dat;
    logic [PIX_W+1:0] quad;
    logic             lb_wr_en;
    logic             lb_rd_en;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)                   prev <= '0;
        else if (valid && !col[0])  prev <= din;
    end

    assign pair     = {1'b0, prev} + {1'b0, din};
    assign lb_wr_en = valid && (state == S_KEEP) && col[0];
    // Read issued on the even column so the pair sum is waiting when the odd column arrives.
    assign lb_rd_en = valid && (state == S_DROP) && !col[0];
    assign quad     = {1'b0, lb_rd_dat} + {2'b00, prev} + {2'b00, din} + (PIX_W+2)'(2);
    assign pix_nxt  = quad[PIX_W+1:2];

    ds_line_buffer #(
        .DEPTH (LB_DEPTH),
        .AW    (LB_AW),
        .DW    (PIX_W + 1)
    ) u_line_buffer (
        .clk     (clk),
        .wr_en   (lb_wr_en),
        .wr_addr (col[LB_AW:1]),
        .wr_dat  (pair),
        .rd_en   (lb_rd_en),
        .rd_addr (col[LB_AW:1]),
        .rd_dat  (lb_rd_dat)
    );
`else
    assign pix_nxt = din;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            dout       <= '0;
            valid_out  <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            valid_out  <= emit;
            frame_done <= valid && col_last && row_last;
            if (emit) dout <= pix_nxt;
        end
    end
endmodule
